// File: rtl/bin_to_bcd_hex_display.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_hex_display
//   Sequential binary-to-decimal driver for active-low seven-segment digits.
//   When start is accepted, bin is captured. It is then converted with
//   shift-add-3 (double-dabble) at one bit per clock. Results are registered
//   once, in FINISH. Between conversions the outputs do not change.
//
// Handshake: start is a request. It is accepted on any rising edge where
//   busy=0, which includes the cycle in which done is high. busy is high
//   from the accepting edge until FINISH. done is high for one cycle, and
//   bcd/hex/overflow are valid from that cycle until the next done.
//
// Ports
//   CLOCK_50   in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   conversion request, sampled while busy=0
//   bin        in   WIDTH-bit unsigned value
//   busy       out  conversion in progress
//   done       out  one-cycle pulse, new results valid
//   overflow   out  last value >= 10^DIGITS
//   bcd        out  DIGITS BCD digits, digit 0 = units at [3:0]
//   hex        out  DIGITS segment codes, active-low, bit 6 = g .. bit 0 = a
//   dbg_state  out  current FSM state, for observation only
// ---------------------------------------------------------------------------
module bin_to_bcd_hex_display #(
   parameter int WIDTH         = 8,
   parameter int DIGITS        = 3,
   parameter int BLANK_LEADING = 1
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   hex,
   output logic [1:0]            dbg_state
);

   // The scratch area holds enough digits for any WIDTH-bit value,
   // because 2^(3n) < 10^n.
   localparam int NDIG = (WIDTH + 2) / 3;
   localparam int NINT = (DIGITS > NDIG) ? DIGITS : NDIG;
   localparam int CW   = $clog2(WIDTH + 1);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_FINISH  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      sh_q, sh_d;
   logic [4*NINT-1:0]     scr_q, scr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  ovf_q, ovf_d;
   logic [4*DIGITS-1:0]   bcd_q, bcd_d;
   logic [7*DIGITS-1:0]   hex_q, hex_d;

   logic [4*NINT-1:0]     adj;
   logic [4*NINT-1:0]     scr_step;
   logic                  ovf_c;
   logic                  seen_nz;
   logic [3:0]            dig;
   logic [7*DIGITS-1:0]   hex_c;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   // One double-dabble step. Every digit >= 5 is corrected in parallel,
   // and then the MSB of the binary shift register moves into the scratch.
   always_comb begin
      adj = scr_q;
      for (int i = 0; i < NINT; i++) begin
         if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
      scr_step = (adj << 1) | {{(4*NINT-1){1'b0}}, sh_q[WIDTH-1]};
   end

   // Result decode from the completed scratch. Digits are scanned from the
   // top down, so blanking stops at the first nonzero digit. Digit 0 is
   // never blanked.
   always_comb begin
      ovf_c   = 1'b0;
      seen_nz = 1'b0;
      dig     = 4'd0;
      hex_c   = '1;
      for (int i = DIGITS; i < NINT; i++) begin
         if (scr_q[4*i +: 4] != 4'd0) ovf_c = 1'b1;
      end
      for (int i = DIGITS - 1; i >= 0; i--) begin
         dig = scr_q[4*i +: 4];
         if (dig != 4'd0) seen_nz = 1'b1;
         if (ovf_c)
            hex_c[7*i +: 7] = SEG_DASH;
         else if ((BLANK_LEADING != 0) && !seen_nz && (i != 0))
            hex_c[7*i +: 7] = SEG_BLANK;
         else
            hex_c[7*i +: 7] = seg7(dig);
      end
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      scr_d   = scr_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      bcd_d   = bcd_q;
      hex_d   = hex_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               sh_d    = bin;
               scr_d   = '0;
               cnt_d   = CW'(WIDTH);
               busy_d  = 1'b1;
               state_d = S_CONVERT;
            end
         end
         S_CONVERT: begin
            sh_d  = sh_q << 1;
            scr_d = scr_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_FINISH;
         end
         S_FINISH: begin
            bcd_d   = scr_q[4*DIGITS-1:0];
            hex_d   = hex_c;
            ovf_d   = ovf_c;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         bcd_q   <= '0;
         hex_q   <= '1;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         scr_q   <= scr_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         bcd_q   <= bcd_d;
         hex_q   <= hex_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign overflow  = ovf_q;
   assign bcd       = bcd_q;
   assign hex       = hex_q;
   assign dbg_state = state_q;

endmodule

// File: doc/bin_to_bcd_hex_display.md
Name: bin_to_bcd_hex_display

Overview:
- Sequential, parametrised binary-to-decimal display driver for the board's seven-segment HEX digits.
- On a start pulse it captures a WIDTH-bit unsigned value and converts it to BCD using iterative shift-add-3 (double-dabble), one bit per clock.
- It drives DIGITS active-low HEX outputs, with optional leading-zero blanking and overflow indication.
- It succeeds the fixed 4-bit, two-digit combinational converter. Upstream logic hands off values through a start/done handshake.

Parameters:
- WIDTH, 8: bit width of the unsigned binary input, 1..32.
- DIGITS, 3: number of HEX digits driven, 1..10.
- BLANK_LEADING, 1: 1 blanks leading zero digits; 0 shows all zeros.

Ports:
- CLOCK_50  in  1: system clock; all logic on rising edge.
- reset  in  1: synchronous, active-high reset.
- start  in  1: request conversion of bin; sampled only when busy=0.
- bin  in  WIDTH: unsigned binary value, captured on accepted start.
- busy  out  1: conversion in progress.
- done  out  1: one-cycle pulse when new results are valid.
- overflow  out  1: last converted value >= 10^DIGITS.
- bcd  out  4*DIGITS: BCD result; digit i at bits [4i+3:4i], digit 0 = units.
- hex  out  7*DIGITS: segments, digit i at [7i+6:7i]; active-low, bit 6 = g … bit 0 = a.

Behaviour:
- Reset (synchronous, wins over everything, including mid-conversion):
  - FSM → IDLE; busy=0, done=0, overflow=0, bcd=0.
  - All hex digits BLANK (7'b1111111).
  - Any conversion in flight is abandoned.
- FSM states: IDLE, CONVERT, FINISH.
- IDLE:
  - If start=1 at edge k: load shift register ← bin, load scratch BCD ← 0, bit counter ← WIDTH, go to CONVERT, busy=1.
  - Otherwise hold all outputs.
- CONVERT:
  - Each edge: every scratch BCD digit >=5 gets +3 (all digits in parallel, same cycle); then {scratch, shift} shifts left 1; counter decrements.
  - Exactly WIDTH steps, at edges k+1..k+WIDTH, then go to FINISH.
  - start is ignored; bin may change freely.
- FINISH (edge k+WIDTH+1):
  - Register bcd, hex and overflow; done=1 for exactly that one cycle.
  - busy=0; return to IDLE.
- Latency: start accepted → done high = WIDTH+1 cycles; busy high for WIDTH+1 cycles.
- Back-to-back: start=1 in the done cycle is accepted (busy=0 there). The new conversion begins; old outputs hold until its FINISH.
- Scratch width: NINT = max(DIGITS, ceil(WIDTH/3)) digits. This guarantees no loss, since 2^(3n) < 10^n.
- overflow: set when any scratch digit at index >= DIGITS is nonzero. It is constant 0 when NINT = DIGITS.
- bcd: always the low DIGITS scratch digits, including on overflow (i.e. the value mod 10^DIGITS).
- hex, normal case:
  - Digit i = segment code of bcd digit i.
  - Codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- hex, BLANK_LEADING=1: digits above the most significant nonzero digit show BLANK. Digit 0 is never blanked, so value 0 shows a single ZERO.
- hex, overflow=1: every digit shows DASH (7'b0111111).
- Outputs change only at FINISH or reset; they are stable between conversions.

Test Plan:
- WIDTH=8, DIGITS=3, BLANK_LEADING=1; reset 2 cycles; start with bin=255 → done exactly 9 cycles after start; bcd=12'h255; hex2=0100100, hex1=0010010, hex0=0010010; overflow=0; busy high 9 cycles.
- Same config, bin=7 → bcd=12'h007; hex2=hex1=1111111, hex0=1111000. Repeat with BLANK_LEADING=0 → hex2=hex1=1000000. Then bin=0 → hex0=1000000, others blank.
- WIDTH=8, DIGITS=2, bin=100 → overflow=1, bcd=8'h00, both digits 0111111. Then bin=99 → overflow=0, bcd=8'h99.
- start at 255; change bin to 3 and pulse start during busy → second start ignored; result 255. Then start=1 in the done cycle with bin=42 → second done 9 cycles later, bcd=12'h042, with 255 held on outputs until then.
- Assert reset at cycle 4 of a conversion → next cycle busy=0, done=0, bcd=0, all hex BLANK; no done pulse follows.
- WIDTH=16, DIGITS=5, bin=65535 → done after 17 cycles, bcd=20'h65535, overflow=0. Randomised sweep of bin against a reference model: bcd digits and hex codes match for all values.
